// File: rtl/npc_sram_mem_pkg.sv
// ============================================================================
// Package  : npc_mem_pkg
// Purpose  : Shared types and helpers for the NPC SRAM word memory.
//            - state_e   : control FSM states
//            - mem_req_t : holding-register layout of an accepted request
//            - byte_merge: per-byte strobe merge of new data into an old word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package npc_mem_pkg;

  // Native word/address widths of the holding register and merge helper.
  // npc_sram_mem's DATA_W/ADDR_W must match these.
  localparam int NPC_DATA_W = 64;
  localparam int NPC_ADDR_W = 32;
  localparam int NPC_STRB_W = NPC_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                  wen;
    logic [NPC_ADDR_W-1:0] addr;
    logic [NPC_DATA_W-1:0] wdata;
    logic [NPC_STRB_W-1:0] wmask;
  } mem_req_t;

  // Byte i of the result comes from new_w if mask[i], otherwise from old_w.
  function automatic logic [NPC_DATA_W-1:0] byte_merge(
    input logic [NPC_DATA_W-1:0] old_w,
    input logic [NPC_DATA_W-1:0] new_w,
    input logic [NPC_STRB_W-1:0] mask
  );
    logic [NPC_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NPC_STRB_W; i++) begin
      if (mask[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/npc_sram_array.sv
// ============================================================================
// Module   : npc_sram_array
// Purpose  : DEPTH x DATA_W storage, one synchronous read port and one
//            byte-masked write port. Contents are not reset.
// Ports    : clk     - clock
//            we_i    - write enable (masked write of wdata_i at idx_i)
//            wmask_i - byte strobes for the write
//            wdata_i - write data
//            re_i    - read enable (registers the word at idx_i)
//            idx_i   - word index shared by both ports
//            rdata_o - registered read data, held until the next read
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module npc_sram_array
  import npc_mem_pkg::*;
#(
  parameter int DATA_W = NPC_DATA_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] wmask_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= byte_merge(mem_q[idx_i], wdata_i, wmask_i);
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/npc_sram_mem.sv
// ============================================================================
// Module   : npc_sram_mem
// Purpose  : Word memory for the NPC core with valid/ready request and
//            response channels, per-byte write strobes, a base-address window
//            with range-error reporting and a fixed access latency.
//            One outstanding transaction at a time.
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_ready       - request handshake
//            req_wen, req_addr         - 1 = write; byte address
//            req_wdata, req_wmask      - write data and byte strobes
//            resp_valid/resp_ready     - response handshake
//            resp_rdata                - read data (0 for writes and errors)
//            resp_err                  - address outside the window
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module npc_sram_mem
  import npc_mem_pkg::*;
#(
  parameter int                DATA_W    = NPC_DATA_W,
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = NPC_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;
  // One extra bit so a window covering the whole address space still compares.
  localparam logic [ADDR_W:0] WINDOW = (ADDR_W+1)'(DEPTH * BYTES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mem_req_t           hold_q, hold_d;

  logic [ADDR_W-1:0]  offset;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               commit;
  logic [DATA_W-1:0]  arr_rdata;

  // Decode runs on the held address; it is stable from acceptance to
  // the response handshake, so resp_err needs no separate register.
  // The subtraction wraps, so addresses below BASE_ADDR land far out of range.
  assign offset   = hold_q.addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < WINDOW);
  assign idx      = offset[OFF_W +: IDX_W];

  assign accept = (state_q == IDLE) && req_valid;
  assign commit = (state_q == WAIT) && (cnt_q == '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)  state_d = WAIT;
      WAIT:    if (commit)     state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && !in_range;
    resp_rdata = '0;
    if ((state_q == RESP) && !hold_q.wen && in_range) begin
      resp_rdata = arr_rdata;
    end
  end

  // ------------------------------------------------ holding regs, counter
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (accept) begin
      cnt_d  = CNT_W'(LATENCY - 1);
      hold_d = '{wen: req_wen, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  // ------------------------------------------------------------- storage
  npc_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (commit && hold_q.wen && in_range),
    .wmask_i (hold_q.wmask),
    .wdata_i (hold_q.wdata),
    .re_i    (commit && !hold_q.wen && in_range),
    .idx_i   (idx),
    .rdata_o (arr_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_npc_sram_mem.sv
// ============================================================================
// Module   : tb_npc_sram_mem
// Purpose  : Self-checking bench for npc_sram_mem (DATA_W=64, DEPTH=256,
//            LATENCY=2): table of directed transactions plus hand-written
//            backpressure and reset-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_npc_sram_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npc_sram_mem #(
    .DATA_W    (64),
    .DEPTH     (256),
    .ADDR_W    (32),
    .BASE_ADDR (32'h8000_0000),
    .LATENCY   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge. Issues one request with resp_ready high and returns
  // the response plus the number of rising edges from acceptance to
  // resp_valid. Returns at the negedge after the response handshake.
  task automatic issue(input logic wen, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [7:0] m,
                       output logic [63:0] rd, output logic er,
                       output int lat, output bit ok);
    int n;
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wd;
    req_wmask  = m;
    resp_ready = 1'b1;
    ok  = 1'b0;
    rd  = '0;
    er  = 1'b0;
    lat = 0;
    n   = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) return;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) return;
    rd = resp_rdata;
    er = resp_err;
    ok = 1'b1;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic wen, input logic [31:0] a, input logic [63:0] d,
                              input logic [7:0] m, input logic [63:0] er_d, input logic ee);
    vec_t v;
    v.wen = wen; v.addr = a; v.wdata = d; v.wmask = m;
    v.exp_rdata = er_d; v.exp_err = ee;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] rd, rd0;
    logic        er;
    int          lat;
    bit          ok;
    int          n;
    bit          stable;

    // Table: writes/reads through the window, including aliasing
    // out-of-range addresses that must not touch words 0 and 255.
    vecs[0]  = mk(1, 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 0);
    vecs[1]  = mk(1, 32'h8000_07F8, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'h0, 0);
    vecs[2]  = mk(1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 0);
    vecs[3]  = mk(0, 32'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 0);
    vecs[4]  = mk(1, 32'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'h0, 0);
    vecs[5]  = mk(0, 32'h8000_0014, 64'h0, 8'h00, 64'h1122_3344_BBBB_BBBB, 0);
    vecs[6]  = mk(0, 32'h8000_0800, 64'h0, 8'h00, 64'h0, 1);
    vecs[7]  = mk(1, 32'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 1);
    vecs[8]  = mk(1, 32'h8000_0800, 64'h6666_6666_6666_6666, 8'hFF, 64'h0, 1);
    vecs[9]  = mk(0, 32'h8000_0000, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0);
    vecs[10] = mk(0, 32'h8000_07FF, 64'h0, 8'h00, 64'hFEDC_BA98_7654_3210, 0);
    vecs[11] = mk(1, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 0);
    vecs[12] = mk(0, 32'h8000_0000, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0);
    vecs[13] = mk(1, 32'h8000_0000, 64'hAA00_0000_0000_00BB, 8'h81, 64'h0, 0);
    vecs[14] = mk(0, 32'h8000_0000, 64'h0, 8'h00, 64'hAA23_4567_89AB_CDBB, 0);
    vecs[15] = mk(1, 32'h8000_0020, 64'h0BAD_F00D_1234_5678, 8'hFF, 64'h0, 0);

    rst_n = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1;
    chk("reset_req_ready",  64'(req_ready),  64'd1);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_resp_rdata", resp_rdata,      64'd0);
    chk("reset_resp_err",   64'(resp_err),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er, lat, ok);
      chk($sformatf("vec%0d_handshake", i), 64'(ok), 64'd1);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
    end

    // Backpressure: response held 5 cycles while req_valid toggles with a
    // write that must never be accepted.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_wen = 1'b1; req_wdata = 64'h9999_9999_9999_9999; req_wmask = 8'hFF;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_resp_valid", 64'(resp_valid), 64'd1);
    rd0 = resp_rdata;
    chk("bp_rdata", rd0, 64'h1122_3344_BBBB_BBBB);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = ~req_valid;
      @(negedge clk);
      if (!resp_valid || resp_rdata !== rd0 || req_ready !== 1'b0 || resp_err !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_valid", 64'(resp_valid), 64'd0);
    chk("bp_after_ready", 64'(req_ready),  64'd1);
    issue(1'b0, 32'h8000_0010, 64'h0, 8'h00, rd, er, lat, ok);
    chk("bp_no_second_accept", rd, 64'h1122_3344_BBBB_BBBB);

    // Reset one cycle after acceptance, before the commit edge.
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_wait", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) stable = 1'b0;
    end
    chk("abort_no_resp", 64'(stable), 64'd1);
    issue(1'b0, 32'h8000_0020, 64'h0, 8'h00, rd, er, lat, ok);
    chk("abort_read_ok", 64'(ok), 64'd1);
    chk("abort_read_data", rd, 64'h0BAD_F00D_1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
